// File: rtl/pll_mdrp_pkg.sv
// Shared opcodes, FSM state encodings and register constants for the PLL MDRP sequencer.
package pll_mdrp_pkg;
  localparam logic [1:0] OPC_NOP  = 2'b00;
  localparam logic [1:0] OPC_WR   = 2'b01;
  localparam logic [1:0] OPC_RD   = 2'b10;
  localparam logic [1:0] OPC_ADDR = 2'b11;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_ADDR      = 4'd1;
  localparam logic [3:0] S_WRITE     = 4'd2;
  localparam logic [3:0] S_READ      = 4'd3;
  localparam logic [3:0] S_CMP       = 4'd4;
  localparam logic [3:0] S_RST       = 4'd5;
  localparam logic [3:0] S_WAIT_LOCK = 4'd6;
  localparam logic [3:0] S_DONE      = 4'd7;
  localparam logic [3:0] S_ERR       = 4'd8;

  localparam logic [7:0] ODIV0_ADDR = 8'h12;
endpackage

// File: rtl/pll_mdrp_clkgen.sv
// Free-running md_clk divider; strobes mark the clk edge on which md_clk falls or rises.
module pll_mdrp_clkgen #(
  parameter int MD_HALF = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic md_clk,
  output logic fall_stb,
  output logic rise_stb
);
  localparam int CW = $clog2(MD_HALF);

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap     = (cnt == CW'(MD_HALF - 1));
  assign fall_stb = wrap & md_clk;
  assign rise_stb = wrap & ~md_clk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      md_clk <= 1'b0;
    end else if (wrap) begin
      cnt    <= '0;
      md_clk <= ~md_clk;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/pll_mdrp_sequencer.sv
// One MDRP reconfiguration per request: address, write, (optional readback), PLL reset, relock wait.
// Readback verification is built when PLL_MDRP_READBACK_EN is defined.
module pll_mdrp_sequencer
  import pll_mdrp_pkg::*;
#(
  parameter int MD_HALF      = 4,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_data,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic       md_clk,
  output logic [1:0] md_opc,
  output logic       md_ainc,
  output logic [7:0] md_wdi,
  input  logic [7:0] md_rdo
);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);

  logic [3:0]    state;
  logic [7:0]    addr_q, data_q;
  logic          issued;
  logic [RW-1:0] rst_cnt;
  logic [TW-1:0] to_cnt;
  logic          lock_m, lock_s;
  logic          md_fall, md_rise;

  pll_mdrp_clkgen #(.MD_HALF(MD_HALF)) u_clkgen (
    .clk      (clk),
    .rst_n    (rst_n),
    .md_clk   (md_clk),
    .fall_stb (md_fall),
    .rise_stb (md_rise)
  );

  assign req_ready = (state == S_IDLE);
  assign busy      = ~req_ready;
  assign done      = (state == S_DONE);
  assign err       = (state == S_ERR);
  assign md_ainc   = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {lock_s, lock_m} <= 2'b00;
    else        {lock_s, lock_m} <= {lock_m, pll_lock};
  end

`ifdef PLL_MDRP_READBACK_EN
  logic [7:0] rd_q;
`else
  logic unused_rb;
  assign unused_rb = ^{md_rdo, md_rise};
`endif

  // Opcode/data only move on md_fall, so the PLL sees them stable across its rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      issued    <= 1'b0;
      rst_cnt   <= '0;
      to_cnt    <= '0;
      pll_reset <= 1'b0;
      md_opc    <= OPC_NOP;
      md_wdi    <= '0;
`ifdef PLL_MDRP_READBACK_EN
      rd_q      <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          addr_q <= req_addr;
          data_q <= req_data;
          issued <= 1'b0;
          state  <= S_ADDR;
        end
        S_ADDR: if (md_fall) begin
          if (!issued) begin
            md_opc <= OPC_ADDR;
            md_wdi <= addr_q;
            issued <= 1'b1;
          end else begin
            md_opc <= OPC_WR;
            md_wdi <= data_q;
            state  <= S_WRITE;
          end
        end
        S_WRITE: if (md_fall) begin
`ifdef PLL_MDRP_READBACK_EN
          md_opc <= OPC_RD;
          state  <= S_READ;
`else
          md_opc    <= OPC_NOP;
          pll_reset <= 1'b1;
          rst_cnt   <= '0;
          state     <= S_RST;
`endif
        end
`ifdef PLL_MDRP_READBACK_EN
        // Read data appears on the rise inside the RD period; capture it on the following rise.
        S_READ: begin
          if (md_fall && issued) begin
            md_opc <= OPC_NOP;
            issued <= 1'b0;
          end else if (md_rise && !issued) begin
            rd_q  <= md_rdo;
            state <= S_CMP;
          end
        end
        S_CMP: begin
          if (rd_q == data_q) begin
            pll_reset <= 1'b1;
            rst_cnt   <= '0;
            state     <= S_RST;
          end else begin
            state <= S_ERR;
          end
        end
`endif
        S_RST: begin
          if (rst_cnt == RW'(RST_CYCLES - 1)) begin
            pll_reset <= 1'b0;
            to_cnt    <= '0;
            state     <= S_WAIT_LOCK;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          if (lock_s)                                   state  <= S_DONE;
          else if (to_cnt == TW'(LOCK_TIMEOUT - 1))     state  <= S_ERR;
          else                                          to_cnt <= to_cnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pll_mdrp_sequencer.sv
// Directed bench for pll_mdrp_sequencer with a behavioural MDRP/PLL model and an md_clk setup checker.
module tb_pll_mdrp_sequencer;
  import pll_mdrp_pkg::*;

  typedef struct {
    logic [7:0] addr, data;
    int         relock;
    bit         corrupt;
    bit         exp_done, exp_err;
    int         exp_rst, exp_lat;
    logic [7:0] exp_reg;
  } vec_t;

`ifdef PLL_MDRP_READBACK_EN
  localparam int NOPS = 3;
`else
  localparam int NOPS = 2;
`endif

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       req_valid = 1'b0, req_ready, busy, done, err, pll_reset, md_clk, md_ainc;
  logic [7:0] req_addr = '0, req_data = '0, md_wdi, md_rdo = '0;
  logic [1:0] md_opc;
  logic       pll_lock = 1'b1;

  logic       req_valid7 = 1'b0, req_ready7, busy7, done7, err7, pll_reset7, md_clk7, md_ainc7;
  logic [7:0] req_addr7 = '0, req_data7 = '0, md_wdi7, reg7 = '0;
  logic [1:0] md_opc7;

  always #5 clk = ~clk;

  pll_mdrp_sequencer #(.MD_HALF(2), .RST_CYCLES(16), .LOCK_TIMEOUT(1000)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .busy(busy), .done(done), .err(err),
    .pll_lock(pll_lock), .pll_reset(pll_reset), .md_clk(md_clk), .md_opc(md_opc),
    .md_ainc(md_ainc), .md_wdi(md_wdi), .md_rdo(md_rdo));

  pll_mdrp_sequencer #(.MD_HALF(7)) u_dut7 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid7), .req_ready(req_ready7),
    .req_addr(req_addr7), .req_data(req_data7), .busy(busy7), .done(done7), .err(err7),
    .pll_lock(1'b1), .pll_reset(pll_reset7), .md_clk(md_clk7), .md_opc(md_opc7),
    .md_ainc(md_ainc7), .md_wdi(md_wdi7), .md_rdo(reg7));

  // MDRP model: address pointer, register file, optional write corruption
  logic [7:0] mregs [256];
  logic [7:0] mptr = '0;
  bit         corrupt = 1'b0;
  int         relock_n = 40, rc = 0;
  logic [1:0] opq [$];
  logic [7:0] wdq [$];

  always @(posedge md_clk) begin
    case (md_opc)
      OPC_ADDR: mptr <= md_wdi;
      OPC_WR:   mregs[mptr] <= corrupt ? md_wdi + 8'd1 : md_wdi;
      OPC_RD:   md_rdo <= mregs[mptr];
      default: ;
    endcase
    if (md_opc != OPC_NOP) begin
      opq.push_back(md_opc);
      wdq.push_back(md_wdi);
    end
  end

  always @(posedge md_clk7) if (md_opc7 == OPC_WR) reg7 <= md_wdi7;

  // PLL model: lock drops while reset, relocks relock_n clk cycles after release (0 = never)
  always @(posedge clk) begin
    if (pll_reset) begin
      pll_lock <= 1'b0;
      rc       <= 0;
    end else if (!pll_lock && relock_n != 0) begin
      rc <= rc + 1;
      if (rc + 1 == relock_n) pll_lock <= 1'b1;
    end
  end

  // Setup checker: opc/wdi must be stable for MD_HALF clk cycles before every md_clk rise
  int         since0 = 100, since7 = 100, proto_viol = 0, rises = 0;
  logic [9:0] prev0 = '0, prev7 = '0;
  logic       pclk0 = 1'b0, pclk7 = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      since0 = 100;
      since7 = 100;
    end else begin
      since0 = ({md_opc, md_wdi} != prev0) ? 0 : since0 + 1;
      since7 = ({md_opc7, md_wdi7} != prev7) ? 0 : since7 + 1;
      if (md_clk && !pclk0) begin
        rises++;
        if (since0 < 2) begin proto_viol++; $display("protocol: MD_HALF=2 change %0d cycles before rise at %0t", since0, $time); end
      end
      if (md_clk7 && !pclk7) begin
        rises++;
        if (since7 < 7) begin proto_viol++; $display("protocol: MD_HALF=7 change %0d cycles before rise at %0t", since7, $time); end
      end
    end
    prev0 = {md_opc, md_wdi};
    prev7 = {md_opc7, md_wdi7};
    pclk0 = md_clk;
    pclk7 = md_clk7;
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_req(input logic [7:0] a, input logic [7:0] d);
    int t = 0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_data = d;
    while (!req_ready && t < 20000) begin @(negedge clk); t++; end
    @(negedge clk);
    req_valid = 1'b0;
    chk("accept_in_time", 32'(t < 20000), 1);
    chk("ready_drops", req_ready, 0);
  endtask

  // Samples from the current negedge until a done/err pulse; lat counts from the negedge
  // on which pll_reset is first seen low again.
  task automatic wait_pulse(output int rst_hi, output int lat, output int pd, output int pe);
    int   k = -1;
    logic prv = 1'b0;
    rst_hi = 0; lat = -1; pd = 0; pe = 0;
    for (int c = 0; c < 5000; c++) begin
      if (pll_reset) rst_hi++;
      if (prv && !pll_reset) k = 0;
      else if (k >= 0) k++;
      prv = pll_reset;
      if (done || err) begin pd = int'(done); pe = int'(err); lat = k; break; end
      @(negedge clk);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int rh, lat, pd, pe, q0;
    relock_n = v.relock;
    corrupt  = v.corrupt;
    q0       = opq.size();
    send_req(v.addr, v.data);
    wait_pulse(rh, lat, pd, pe);
    chk({tag, ".done"}, pd, 32'(v.exp_done));
    chk({tag, ".err"}, pe, 32'(v.exp_err));
    chk({tag, ".rst_hi"}, rh, v.exp_rst);
    chk({tag, ".latency"}, lat, v.exp_lat);
    @(negedge clk);
    chk({tag, ".pulse_1cyc"}, {done, err}, 0);
    chk({tag, ".idle"}, {req_ready, busy}, 2'b10);
    chk({tag, ".reg"}, mregs[v.addr], v.exp_reg);
    chk({tag, ".n_ops"}, opq.size() - q0, NOPS);
    if (opq.size() - q0 >= 2) begin
      chk({tag, ".op0"}, {opq[q0], wdq[q0]}, {OPC_ADDR, v.addr});
      chk({tag, ".op1"}, {opq[q0+1], wdq[q0+1]}, {OPC_WR, v.data});
    end
`ifdef PLL_MDRP_READBACK_EN
    if (opq.size() - q0 >= 3) chk({tag, ".op2"}, opq[q0+2], OPC_RD);
`endif
    corrupt = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [$];
    int   k, rh, lat, pd, pe, seen;
    logic prv;
    bit   got;

    tbl.push_back('{8'h12, 8'h64, 40,  1'b0, 1'b1, 1'b0, 16, 43,   8'h64});
    tbl.push_back('{8'hA5, 8'h3C, 1,   1'b0, 1'b1, 1'b0, 16, 4,    8'h3C});
    tbl.push_back('{8'hFF, 8'h00, 200, 1'b0, 1'b1, 1'b0, 16, 203,  8'h00});
    tbl.push_back('{8'h00, 8'hFF, 0,   1'b0, 1'b0, 1'b1, 16, 1000, 8'hFF});
    tbl.push_back('{8'h7E, 8'h81, 5,   1'b0, 1'b1, 1'b0, 16, 8,    8'h81});
`ifdef PLL_MDRP_READBACK_EN
    tbl.push_back('{8'h30, 8'h64, 5,   1'b1, 1'b0, 1'b1, 0,  -1,   8'h65});
`else
    tbl.push_back('{8'h30, 8'h64, 5,   1'b1, 1'b1, 1'b0, 16, 8,    8'h65});
`endif

    repeat (3) @(negedge clk);
    chk("reset.ctl", {req_ready, busy, done, err, pll_reset, md_clk, md_ainc}, 7'b1000000);
    chk("reset.md", {md_opc, md_wdi}, 10'h000);
    chk("reset.dut7", {req_ready7, busy7, pll_reset7, md_clk7, md_opc7, md_ainc7}, 7'b1000000);
    rst_n = 1'b1;

    // MD_HALF=7 instance, lock already high when WAIT_LOCK is entered
    @(negedge clk);
    req_valid7 = 1'b1; req_addr7 = 8'h33; req_data7 = 8'h44;
    @(negedge clk);
    req_valid7 = 1'b0;
    k = -1; prv = 1'b0; got = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (prv && !pll_reset7) k = 0;
      else if (k >= 0) k++;
      prv = pll_reset7;
      if (done7) begin got = 1'b1; break; end
    end
    chk("d7.done", 32'(got), 1);
    chk("d7.err", err7, 0);
    chk("d7.lat", k, 1);
    chk("d7.reg", reg7, 8'h44);
    @(negedge clk);
    chk("d7.idle", {req_ready7, busy7, done7}, 3'b100);

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Second request held while busy: accepted only after the first completes
    relock_n = 10;
    send_req(8'h21, 8'h9A);
    req_valid = 1'b1; req_addr = 8'h43; req_data = 8'hB7;
    seen = 0;
    for (int c = 0; c < 5000; c++) begin
      if (req_ready) seen++;
      if (done || err) break;
      @(negedge clk);
    end
    chk("held.not_accepted", seen, 0);
    chk("held.first_done", {done, err}, 2'b10);
    @(negedge clk);
    chk("held.ready_idle", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("held.accepted", {req_ready, busy}, 2'b01);
    wait_pulse(rh, lat, pd, pe);
    chk("held.second_done", pd, 1);
    chk("held.second_lat", lat, 13);
    chk("held.reg_b", mregs[8'h43], 8'hB7);
    chk("held.reg_a", mregs[8'h21], 8'h9A);
    @(negedge clk);

    // Reset during the PLL reset phase
    relock_n = 30;
    send_req(8'h55, 8'h66);
    seen = 0;
    while (!pll_reset && seen < 500) begin @(negedge clk); seen++; end
    chk("midrst.reached_rst", pll_reset, 1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst.outputs", {req_ready, busy, done, err, pll_reset, md_clk, md_opc}, 8'b10000000);
    chk("midrst.wdi", md_wdi, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_vec('{8'h5A, 8'hA5, 7, 1'b0, 1'b1, 1'b0, 16, 10, 8'hA5}, "after_rst");

    chk("proto.rises_seen", 32'(rises > 100), 1);
    chk("proto.violations", proto_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
